// File: rtl/serial_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_demux_pkg
// Purpose  : Shared encodings for the serial-to-parallel demultiplexer:
//            FSM state codes and fill-direction codes.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package serial_demux_pkg;

    // FSM state encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    // Fill direction
    localparam logic DIR_LSB = 1'b0;   // index counts up from bit 0
    localparam logic DIR_MSB = 1'b1;   // index counts down from bit WIDTH-1

endpackage : serial_demux_pkg
`default_nettype wire

// File: rtl/serial_demux_counter.sv
`default_nettype none
// ============================================================================
// Module   : dir_bit_counter
// Purpose  : CW-bit up/down bit-position counter for serial_demux.
//            A load selects 0 or WIDTH-1. When load and step are both asserted,
//            the step is applied to the loaded value. The counter therefore
//            reaches the second position of a word in a single cycle.
// Ports    : clk, rst_n     - clock, async active-low reset
//            load_i         - load a start value
//            load_top_i     - start value select: 0 -> 0, 1 -> WIDTH-1
//            step_i         - step the (possibly just loaded) value by one
//            down_i         - step direction (1 = down); also selects which
//                             end of the range is the terminal count
//            idx_o          - current index
//            tc_o           - index sits at the last position for down_i
// Revision : 1.0 - initial release
// ============================================================================
module dir_bit_counter #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic          load_top_i,
    input  logic          step_i,
    input  logic          down_i,
    output logic [CW-1:0] idx_o,
    output logic          tc_o
);

    localparam logic [CW-1:0] c_TOP = CW'(WIDTH - 1);
    localparam logic [CW-1:0] c_ONE = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] w_base;

    always_comb begin
        w_base = cnt_q;
        if (load_i) begin
            w_base = load_top_i ? c_TOP : '0;
        end
        cnt_d = w_base;
        if (step_i) begin
            cnt_d = down_i ? (w_base - c_ONE) : (w_base + c_ONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign idx_o = cnt_q;
    assign tc_o  = down_i ? (cnt_q == '0) : (cnt_q == c_TOP);

endmodule : dir_bit_counter
`default_nettype wire

// File: rtl/serial_demux.sv
`default_nettype none
// ============================================================================
// Module   : serial_demux
// Purpose  : Serial-to-parallel demultiplexer. Assembles WIDTH serial bits
//            LSB-first or MSB-first into a word. Each completed word is
//            presented on a valid/ready port. A sticky overrun flag records
//            any word that was dropped because the port was still occupied.
// Ports    : clk, rst_n      - clock, async active-low reset
//            din_i           - serial data bit
//            din_valid_i     - din_i is sampled this cycle
//            dir_i           - fill order (0 LSB-first, 1 MSB-first), latched
//                              on the first bit of each word
//            flush_i         - abort the partial word
//            clr_ovr_i       - clear the overrun flag
//            dout_o          - completed word
//            dout_valid_o    - dout_o holds an unconsumed word
//            dout_ready_i    - consumer accepts dout_o this cycle
//            busy_o          - a partial word is in progress
//            overrun_o       - sticky dropped-word flag
// Revision : 1.0 - initial release
// ============================================================================
module serial_demux
    import serial_demux_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_i,
    input  logic             din_valid_i,
    input  logic             dir_i,
    input  logic             flush_i,
    input  logic             clr_ovr_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             dout_valid_o,
    input  logic             dout_ready_i,
    output logic             busy_o,
    output logic             overrun_o
);

    localparam logic [CW-1:0] c_TOP = CW'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             overrun_q, overrun_d;

    logic             w_take;       // a bit is consumed this cycle
    logic             w_done;       // this bit completes the word
    logic [CW-1:0]    w_pos;        // shadow bit written this cycle
    logic             w_cnt_load;
    logic             w_cnt_top;
    logic             w_cnt_step;
    logic             w_cnt_down;
    logic [CW-1:0]    w_idx;
    logic             w_tc;

    // flush wins over a simultaneous bit
    assign w_take = din_valid_i & ~flush_i;
    assign w_done = (state_q == ST_FILL) & w_take & w_tc;

    dir_bit_counter #(
        .WIDTH (WIDTH)
    ) u_idx (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (w_cnt_load),
        .load_top_i (w_cnt_top),
        .step_i     (w_cnt_step),
        .down_i     (w_cnt_down),
        .idx_o      (w_idx),
        .tc_o       (w_tc)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_take)           state_d = ST_FILL;
            ST_FILL: if (flush_i || w_done) state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs / counter controls ----------------
    always_comb begin
        w_cnt_load = 1'b0;
        w_cnt_top  = 1'b0;
        w_cnt_step = 1'b0;
        w_cnt_down = dir_q;
        w_pos      = w_idx;
        busy_o     = (state_q == ST_FILL);
        if (state_q == ST_IDLE) begin
            // First bit goes to the end chosen by the live dir input; the
            // counter loads that end and steps past it in the same cycle.
            w_cnt_down = dir_i;
            w_pos      = (dir_i == DIR_MSB) ? c_TOP : '0;
            if (flush_i) begin
                w_cnt_load = 1'b1;
            end else if (w_take) begin
                w_cnt_load = 1'b1;
                w_cnt_top  = (dir_i == DIR_MSB);
                w_cnt_step = 1'b1;
            end
        end else begin
            if (flush_i || w_done) begin
                // Park the index at 0 instead of stepping past the range end
                w_cnt_load = 1'b1;
            end else if (w_take) begin
                w_cnt_step = 1'b1;
            end
        end
    end

    // ---------------- Datapath: shadow word and direction latch ----------------
    always_comb begin
        shadow_d = shadow_q;
        dir_d    = dir_q;
        if (flush_i) begin
            shadow_d = '0;
        end else if (w_take) begin
            shadow_d[w_pos] = din_i;
            if (state_q == ST_IDLE) begin
                dir_d = dir_i;
            end
        end
    end

    // ---------------- Output register, handshake, overrun ----------------
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = overrun_q;
        if (clr_ovr_i) begin
            overrun_d = 1'b0;
        end
        if (w_done) begin
            if (!dout_valid_q || dout_ready_i) begin
                dout_d       = shadow_d;   // includes the bit written now
                dout_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;          // set beats clear
            end
        end else if (dout_ready_i) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q        <= DIR_LSB;
            shadow_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            dir_q        <= dir_d;
            shadow_q     <= shadow_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = dout_valid_q;
    assign overrun_o    = overrun_q;

endmodule : serial_demux
`default_nettype wire

// File: tb/tb_serial_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_demux
// Purpose  : Directed self-checking bench for serial_demux (WIDTH = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_demux;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             din;
    logic             din_valid;
    logic             dir;
    logic             flush;
    logic             clr_ovr;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic             overrun;

    int tests = 0;
    int fails = 0;

    serial_demux #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din_i        (din),
        .din_valid_i  (din_valid),
        .dir_i        (dir),
        .flush_i      (flush),
        .clr_ovr_i    (clr_ovr),
        .dout_o       (dout),
        .dout_valid_o (dout_valid),
        .dout_ready_i (dout_ready),
        .busy_o       (busy),
        .overrun_o    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one rising edge, then settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // send seq[7] first ... seq[0] last, back to back
    task automatic send_word(input logic [7:0] seq, input logic d,
                             input logic toggle, input logic last_rdy);
        logic saved_rdy;
        saved_rdy = dout_ready;
        dir = d;
        for (int i = 7; i >= 0; i--) begin
            din       = seq[i];
            din_valid = 1'b1;
            if (toggle && i < 7) dir = ~dir;
            if (i == 0) dout_ready = saved_rdy | last_rdy;
            step();
        end
        din_valid  = 1'b0;
        din        = 1'b0;
        dir        = d;
        dout_ready = saved_rdy;
    endtask

    initial begin
        rst_n      = 1'b0;
        din        = 1'b0;
        din_valid  = 1'b0;
        dir        = 1'b0;
        flush      = 1'b0;
        clr_ovr    = 1'b0;
        dout_ready = 1'b1;
        #12;
        check("rst_dout", 32'(dout), 32'h00);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        step();

        // LSB-first: 1,0,1,1,0,0,1,0 -> 8'h4D
        send_word(8'b1011_0010, 1'b0, 1'b0, 1'b0);
        check("lsb_dout", 32'(dout), 32'h4D);
        check("lsb_valid", 32'(dout_valid), 32'd1);
        check("lsb_busy", 32'(busy), 32'd0);
        step();
        check("lsb_valid_1cyc", 32'(dout_valid), 32'd0);

        // MSB-first: same bits -> 8'hB2
        send_word(8'b1011_0010, 1'b1, 1'b0, 1'b0);
        check("msb_dout", 32'(dout), 32'hB2);
        check("msb_valid", 32'(dout_valid), 32'd1);
        step();

        // dir toggling mid-word is ignored
        send_word(8'b1011_0010, 1'b1, 1'b1, 1'b0);
        check("msb_toggle_dout", 32'(dout), 32'hB2);
        step();
        send_word(8'b1011_0010, 1'b0, 1'b1, 1'b0);
        check("lsb_toggle_dout", 32'(dout), 32'h4D);
        step();
        check("lsb_toggle_idle", 32'(dout_valid), 32'd0);

        // Back-pressure: two back-to-back words, ready low
        dout_ready = 1'b0;
        send_word(8'b1011_0010, 1'b0, 1'b0, 1'b0);
        check("bp_first_valid", 32'(dout_valid), 32'd1);
        check("bp_first_ovr", 32'(overrun), 32'd0);
        send_word(8'b1111_1111, 1'b0, 1'b0, 1'b0);
        check("bp_keep_dout", 32'(dout), 32'h4D);
        check("bp_keep_valid", 32'(dout_valid), 32'd1);
        check("bp_ovr_set", 32'(overrun), 32'd1);
        clr_ovr    = 1'b1;
        dout_ready = 1'b1;
        step();
        clr_ovr = 1'b0;
        check("bp_clr_ovr", 32'(overrun), 32'd0);
        check("bp_clr_valid", 32'(dout_valid), 32'd0);

        // Completion coincident with acceptance
        dout_ready = 1'b0;
        send_word(8'b1011_0010, 1'b0, 1'b0, 1'b0);
        send_word(8'b0000_1111, 1'b0, 1'b0, 1'b1);
        check("sim_dout", 32'(dout), 32'hF0);
        check("sim_valid", 32'(dout_valid), 32'd1);
        check("sim_ovr", 32'(overrun), 32'd0);
        dout_ready = 1'b1;
        step();
        check("sim_accept", 32'(dout_valid), 32'd0);

        // Flush after 5 bits, together with din_valid
        for (int i = 0; i < 5; i++) begin
            din       = 1'b1;
            din_valid = 1'b1;
            step();
        end
        check("fl_busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        step();
        flush     = 1'b0;
        din_valid = 1'b0;
        din       = 1'b0;
        check("fl_busy_after", 32'(busy), 32'd0);
        check("fl_valid_unaff", 32'(dout_valid), 32'd0);
        send_word(8'b0100_0001, 1'b0, 1'b0, 1'b0);
        check("fl_clean_dout", 32'(dout), 32'h82);
        check("fl_clean_valid", 32'(dout_valid), 32'd1);
        step();

        // Reset mid-word with outputs all nonzero
        dout_ready = 1'b0;
        send_word(8'b1011_0010, 1'b0, 1'b0, 1'b0);
        send_word(8'b1111_1111, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            din       = 1'b1;
            din_valid = 1'b1;
            step();
        end
        din_valid = 1'b0;
        check("rm_busy_pre", 32'(busy), 32'd1);
        check("rm_ovr_pre", 32'(overrun), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rm_dout", 32'(dout), 32'h00);
        check("rm_valid", 32'(dout_valid), 32'd0);
        check("rm_busy", 32'(busy), 32'd0);
        check("rm_ovr", 32'(overrun), 32'd0);
        #1 rst_n = 1'b1;
        dout_ready = 1'b1;
        step();
        send_word(8'b1011_0010, 1'b1, 1'b0, 1'b0);
        check("rm_after_dout", 32'(dout), 32'hB2);
        check("rm_after_valid", 32'(dout_valid), 32'd1);
        check("rm_after_ovr", 32'(overrun), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_serial_demux
`default_nettype wire

// File: doc/serial_demux.md
# serial_demux

Serial-to-parallel demultiplexer with direction control: it routes a one-bit serial stream into the bit positions of a WIDTH-bit word and presents completed words on a valid/ready output port. It is the receive-side counterpart of the 2:1 selector path that serializes data. It sits between a serial source and the parallel consumer of the counter/direction-control design. An up/down bit-position counter picks the destination bit, so words can be assembled LSB-first or MSB-first.

## Interface
- WIDTH, 8: word width in bits; legal range 2..32.
- CW, $clog2(WIDTH): bit-index counter width; derived, never overridden.
- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  asynchronous active-low reset.
- din  in  1  serial data bit.
- din_valid  in  1  din is sampled this cycle.
- dir  in  1  fill order: 0 = LSB-first (index counts up), 1 = MSB-first (index counts down). Latched on the first bit of each word.
- flush  in  1  synchronous abort of the partial word.
- clr_ovr  in  1  synchronous clear of the overrun flag.
- dout  out  WIDTH  completed word.
- dout_valid  out  1  dout holds an unconsumed word.
- dout_ready  in  1  consumer accepts dout this cycle.
- busy  out  1  a partial word is in progress.
- overrun  out  1  sticky; set when a completed word had to be dropped.

## Operation
- Reset values: dout=0, dout_valid=0, busy=0, overrun=0. Internal state: shadow word=0, index=0, state=IDLE.
- State IDLE, when din_valid=1:
  - latch dir as dir_q;
  - write din to shadow[0] if dir=0, or to shadow[WIDTH-1] if dir=1;
  - set index to the next position (1 or WIDTH-2);
  - go to FILL.
- State FILL, when din_valid=1:
  - write din to shadow[index];
  - step the index up (dir_q=0) or down (dir_q=1).
  - The bit written at index WIDTH-1 (dir_q=0) or index 0 (dir_q=1) completes the word; go to IDLE.
- In FILL, cycles with din_valid=0 hold all state; there are no gaps or timeouts.
- Changes on dir while in FILL are ignored.
- Handling a completed word:
  - If dout_valid=0, or dout_ready=1 in the same cycle: load dout with the completed word (including the bit written this cycle) and set dout_valid=1.
  - Otherwise: drop the word, set overrun=1, leave dout unchanged.
- dout_valid clears when dout_ready=1 and no new word completes that cycle.
- flush=1: go to IDLE, set index=0, clear the shadow. din is ignored that cycle (flush wins). dout, dout_valid and overrun are unaffected.
- clr_ovr=1 clears overrun. If an overrun occurs in the same cycle, set wins.
- busy = (state == FILL).
- Index arithmetic is CW bits wide and never wraps out of range: completion always returns the state machine to IDLE before the next step.

## Timing
- Latency: the final bit is sampled at edge N; dout and dout_valid are updated at edge N (visible in cycle N+1).
- Throughput: one bit per cycle; one word per WIDTH cycles with no bubbles.
- Word-to-word: a new word may start in the cycle right after completion.
- dout is stable while dout_valid=1 and dout_ready=0.
- Reset may assert in any state, including mid-word; asynchronous assertion forces all reset values immediately. The first bit after deassertion starts a new word.

## Structure
- Shared package / include file serial_demux_pkg holds:
  - state encodings: ST_IDLE=1'b0, ST_FILL=1'b1;
  - DIR_LSB=1'b0, DIR_MSB=1'b1.
- One sub-module, dir_bit_counter, holds the CW-bit up/down index with these controls:
  - load (value 0 or WIDTH-1);
  - step, with direction;
  - terminal-count output.
- The top level contains the shadow word, the output register, the handshake and the overrun logic.

## Test plan
- LSB-first, WIDTH=8: serial bits 1,0,1,1,0,0,1,0 on consecutive cycles with dir=0, dout_ready=1 -> dout=8'h4D and dout_valid high for exactly one cycle, one cycle after the last bit.
- MSB-first: the same bit sequence with dir=1 -> dout=8'hB2. Toggling dir mid-word -> result unchanged.
- Back-pressure: two back-to-back words with dout_ready=0 -> first word retained on dout, overrun=1, second word lost. Then clr_ovr plus dout_ready=1 -> overrun=0, dout_valid=0.
- Simultaneous completion and acceptance: second word completes in the same cycle dout_ready=1 -> dout updates to the new word, dout_valid stays 1, overrun stays 0.
- Flush: flush after 5 bits, asserted together with din_valid -> busy=0. The next 8 bits form a clean word, with no residue from the flushed bits.
- Reset mid-word: rst_n low after 3 bits -> all outputs 0 asynchronously. A full 8-bit word after release is assembled correctly.
